// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding and requester ids shared by the arbiter and its picker.
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, CAPTURE = 2'd2} state_t;
   localparam logic CPU = 1'b0;
   localparam logic DBG = 1'b1;
endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin winner selection; a tie goes to the side not granted last.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic cpu_req_i,
   input  logic dbg_req_i,
   input  logic last_i,
   output logic win_o,
   output logic valid_o
);
   always_comb begin
      valid_o = cpu_req_i | dbg_req_i;
      win_o   = (cpu_req_i && dbg_req_i) ? ~last_i : (dbg_req_i ? DBG : CPU);
   end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one registered-output RAM between a CPU and a debug panel,
// one access per three cycles (arbitrate, access, capture).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_write,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   input  logic              dbg_req,
   input  logic              dbg_write,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              busy
);
   state_t state_q, state_d;
   logic last_q, id_q, wr_q, cpu_ack_q, dbg_ack_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, cpu_rdata_q, dbg_rdata_q;
   logic win, win_v;
   // A requester being acknowledged this cycle is not eligible, so a held req is not re-granted.
   rr_pick2 u_pick (
      .cpu_req_i (cpu_req & ~cpu_ack_q),
      .dbg_req_i (dbg_req & ~dbg_ack_q),
      .last_i    (last_q),
      .win_o     (win),
      .valid_o   (win_v)
   );
   always_comb begin
      state_d = (state_q == IDLE) ? (win_v ? ACCESS : IDLE) : (state_q == ACCESS) ? CAPTURE : IDLE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         last_q      <= DBG;
         id_q        <= CPU;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
         cpu_ack_q   <= 1'b0;
         dbg_ack_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cpu_ack_q <= (state_q == CAPTURE) && (id_q == CPU);
         dbg_ack_q <= (state_q == CAPTURE) && (id_q == DBG);
         if (state_q == IDLE && win_v) begin
            id_q    <= win;
            last_q  <= win;
            wr_q    <= (win == DBG) ? dbg_write : cpu_write;
            addr_q  <= (win == DBG) ? dbg_addr : cpu_addr;
            wdata_q <= (win == DBG) ? dbg_wdata : cpu_wdata;
         end
         if (state_q == CAPTURE && id_q == CPU) cpu_rdata_q <= mem_dout;
         if (state_q == CAPTURE && id_q == DBG) dbg_rdata_q <= mem_dout;
      end
   end
   assign mem_addr  = addr_q;
   assign mem_din   = wdata_q;
   assign mem_write = (state_q == ACCESS) && wr_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dbg_rdata = dbg_rdata_q;
   assign cpu_ack   = cpu_ack_q;
   assign dbg_ack   = dbg_ack_q;
   assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random two-requester traffic against a transaction-level model.
module tb_mem_arbiter;
   localparam int AW = 8;
   localparam int DW = 16;
   logic clk = 1'b0;
   logic reset;
   logic cpu_req, cpu_write, cpu_ack, dbg_req, dbg_write, dbg_ack, mem_write, busy;
   logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata, dbg_wdata, dbg_rdata, mem_din, mem_dout;
   logic [DW-1:0] ram [256];
   logic bk_en;
   logic [AW-1:0] bk_addr;
   logic [DW-1:0] bk_data;
   int tests = 0;
   int fails = 0;
   int cyc = 0;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .dbg_req(dbg_req), .dbg_write(dbg_write), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
      .mem_addr(mem_addr), .mem_write(mem_write), .mem_din(mem_din), .mem_dout(mem_dout),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Registered-output RAM, write-first, with a bench-only preload port.
   always @(posedge clk) begin
      if (bk_en) ram[bk_addr] <= bk_data;
      else if (mem_write) ram[mem_addr] <= mem_din;
      mem_dout <= mem_write ? mem_din : ram[mem_addr];
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic bk(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bk_en = 1'b1; bk_addr = a; bk_data = d;
      tick();
      bk_en = 1'b0;
   endtask

   task automatic drive(input int r, input logic rq, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (r == 0) begin cpu_req = rq; cpu_write = w; cpu_addr = a; cpu_wdata = d; end
      else begin dbg_req = rq; dbg_write = w; dbg_addr = a; dbg_wdata = d; end
   endtask

   logic [DW-1:0] ref_mem [256];
   bit pend [2];
   bit gnt [2];
   int ack_at [2];
   logic [DW-1:0] exp_rd [2];
   logic rw [2];
   logic [AW-1:0] ra [2];
   logic [DW-1:0] rd [2];
   int mw_at, arb_free, n_mw, n_ack;
   logic [AW-1:0] mw_addr;
   logic [DW-1:0] mw_data;
   bit last, e0, e1;
   int win;

   initial begin
      reset = 1'b1; bk_en = 1'b0; bk_addr = '0; bk_data = '0;
      drive(0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      tick(); tick();
      chk("rst_cpu_ack", cpu_ack, 0);
      chk("rst_dbg_ack", dbg_ack, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_dbg_rdata", dbg_rdata, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_din", mem_din, 0);
      bk(8'd221, 16'd17);
      bk(8'h20, 16'hABCD);
      bk(8'h10, 16'h1111);
      reset = 1'b0;
      tick();

      // CPU-only read of mem[221]
      drive(0, 1, 0, 8'd221, 0);
      tick();
      chk("rd_busy", busy, 1);
      chk("rd_addr", mem_addr, 221);
      chk("rd_mw", mem_write, 0);
      drive(0, 0, 0, 0, 0);
      tick();
      chk("rd_ack_t2", cpu_ack, 0);
      tick();
      chk("rd_ack_t3", cpu_ack, 1);
      chk("rd_data", cpu_rdata, 17);
      tick();
      chk("rd_ack_t4", cpu_ack, 0);
      chk("rd_idle", busy, 0);

      // Debug write of 12 to 0xDD
      drive(1, 1, 1, 8'hDD, 16'd12);
      tick();
      chk("wr_mw_t1", mem_write, 1);
      chk("wr_addr", mem_addr, 8'hDD);
      chk("wr_din", mem_din, 12);
      drive(1, 0, 0, 0, 0);
      tick();
      chk("wr_mw_t2", mem_write, 0);
      chk("wr_ram", ram[221], 12);
      tick();
      chk("wr_ack_t3", dbg_ack, 1);
      chk("wr_cpu_ack", cpu_ack, 0);
      chk("wr_rdata", dbg_rdata, 12);
      tick();
      chk("wr_ack_t4", dbg_ack, 0);

      // Tie right after reset: CPU first, DBG next, repeated tie CPU first again
      reset = 1'b1; tick(); reset = 1'b0;
      drive(0, 1, 0, 8'd221, 0);
      drive(1, 1, 0, 8'h20, 0);
      tick();
      chk("tie_first_addr", mem_addr, 221);
      tick(); tick();
      chk("tie_cpu_ack", cpu_ack, 1);
      chk("tie_dbg_ack_early", dbg_ack, 0);
      chk("tie_cpu_data", cpu_rdata, 12);
      drive(0, 0, 0, 0, 0);
      tick();
      chk("tie_second_addr", mem_addr, 8'h20);
      chk("tie_second_busy", busy, 1);
      tick(); tick();
      chk("tie_dbg_ack", dbg_ack, 1);
      chk("tie_dbg_cpu_ack", cpu_ack, 0);
      chk("tie_dbg_data", dbg_rdata, 16'hABCD);
      drive(1, 0, 0, 0, 0);
      tick();
      drive(0, 1, 0, 8'h10, 0);
      drive(1, 1, 0, 8'h20, 0);
      tick();
      chk("tie2_addr", mem_addr, 8'h10);
      tick(); tick();
      chk("tie2_cpu_ack", cpu_ack, 1);
      chk("tie2_data", cpu_rdata, 16'h1111);
      drive(0, 0, 0, 0, 0);
      tick(); tick(); tick();
      chk("tie2_dbg_ack", dbg_ack, 1);
      drive(1, 0, 0, 0, 0);
      tick();

      // Held request: one access and one ack
      drive(0, 1, 1, 8'h33, 16'h5555);
      n_mw = 0; n_ack = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_mw += int'(mem_write);
         n_ack += int'(cpu_ack);
         if (cpu_ack) drive(0, 0, 0, 0, 0);
      end
      chk("held_mw_count", n_mw, 1);
      chk("held_ack_count", n_ack, 1);
      chk("held_ram", ram[8'h33], 16'h5555);

      // Reset during ACCESS of a write aborts it
      drive(1, 1, 1, 8'h44, 16'h9999);
      tick();
      chk("abort_mw_t1", mem_write, 1);
      reset = 1'b1;
      drive(1, 0, 0, 0, 0);
      tick();
      chk("abort_mw", mem_write, 0);
      chk("abort_busy", busy, 0);
      chk("abort_ack", dbg_ack, 0);
      chk("abort_addr", mem_addr, 0);
      reset = 1'b0;
      tick();
      chk("abort_ack2", dbg_ack, 0);
      tick();
      chk("abort_ack3", dbg_ack, 0);
      chk("abort_busy3", busy, 0);

      // Input change after grant has no effect
      drive(0, 1, 0, 8'h20, 0);
      tick();
      chk("chg_addr_t1", mem_addr, 8'h20);
      drive(0, 0, 0, 8'h10, 0);
      tick();
      chk("chg_addr_t2", mem_addr, 8'h20);
      tick();
      chk("chg_ack", cpu_ack, 1);
      chk("chg_data", cpu_rdata, 16'hABCD);
      tick();

      // Random traffic against a transaction-level model
      for (int i = 0; i < 256; i++) begin
         bk(AW'(i), DW'(i * 257) ^ 16'h5A5A);
         ref_mem[i] = DW'(i * 257) ^ 16'h5A5A;
      end
      last = 1'b0;
      arb_free = cyc;
      mw_at = -1;
      for (int r = 0; r < 2; r++) begin pend[r] = 0; gnt[r] = 0; ack_at[r] = -1; end
      for (int k = 0; k < 400; k++) begin
         if (k >= 300 && !pend[0] && !pend[1]) break;
         chk("rnd_cpu_ack", cpu_ack, ack_at[0] == cyc);
         chk("rnd_dbg_ack", dbg_ack, ack_at[1] == cyc);
         for (int r = 0; r < 2; r++)
            if (ack_at[r] == cyc) begin
               chk(r == 0 ? "rnd_cpu_rdata" : "rnd_dbg_rdata", r == 0 ? cpu_rdata : dbg_rdata, exp_rd[r]);
               pend[r] = 0; gnt[r] = 0;
               drive(r, 0, 0, 0, 0);
            end
         chk("rnd_mem_write", mem_write, mw_at == cyc);
         if (mw_at == cyc) begin
            chk("rnd_mw_addr", mem_addr, mw_addr);
            chk("rnd_mw_data", mem_din, mw_data);
         end
         for (int r = 0; r < 2; r++)
            if (!pend[r] && ack_at[r] != cyc && k < 300 && $urandom_range(0, 2) == 0) begin
               pend[r] = 1;
               rw[r] = 1'($urandom);
               ra[r] = AW'($urandom);
               rd[r] = DW'($urandom);
               drive(r, 1, rw[r], ra[r], rd[r]);
            end
         e0 = pend[0] && !gnt[0];
         e1 = pend[1] && !gnt[1];
         if (cyc >= arb_free && (e0 || e1)) begin
            win = (e0 && e1) ? int'(!last) : int'(e1);
            gnt[win] = 1;
            ack_at[win] = cyc + 3;
            exp_rd[win] = rw[win] ? rd[win] : ref_mem[ra[win]];
            if (rw[win]) begin
               ref_mem[ra[win]] = rd[win];
               mw_at = cyc + 1; mw_addr = ra[win]; mw_data = rd[win];
            end
            last = win[0];
            arb_free = cyc + 3;
         end
         tick();
      end
      chk("rnd_drained", {30'd0, pend[0], pend[1]}, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
